// File: rtl/usb_uart_pkg.sv
// Shared definitions for the status-stream UART blocks: FSM state
// encoding, default clock rate and the bit-period divisor helper.
package usb_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } uart_tx_state_e;

    localparam int unsigned DEFAULT_CLK_HZ = 48_000_000;
    localparam int unsigned DEFAULT_BAUD   = 115_200;

    // Clock cycles per bit, truncated.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period timer. Held at zero while load is high, then
// counts 0..DIV-1 and wraps; tick marks the last cycle of each bit.
module uart_bit_timer #(
    parameter int unsigned DIV = 416
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);

    localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    // Next count: restart on load or at the end of a bit period.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (load || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/usb_status_uart_tx.sv
// Status-stream consumer: requests bytes from the status generator with a
// one-cycle inc pulse and serialises each one as 8N1 (LSB first) on tx.
module usb_status_uart_tx
    import usb_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = DEFAULT_CLK_HZ,
    parameter int unsigned BAUD      = DEFAULT_BAUD,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned WAIT_MAX  = 4
) (
    input  logic       clk48,
    input  logic       rst,
    input  logic       en,
    output logic       inc,
    input  logic [7:0] din,
    input  logic       din_v,
    output logic       tx,
    output logic       busy,
    output logic       ovr
);

    localparam int unsigned    DIV       = calc_div(CLK_HZ, BAUD);
    localparam int unsigned    WCW       = $clog2(WAIT_MAX + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);
    localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);

    uart_tx_state_e state_q, state_d;
    logic [7:0]     shreg_q, shreg_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           tx_q, tx_d;
    logic           inc_q, inc_d;
    logic           busy_q, busy_d;
    logic           ovr_q, ovr_d;
    logic           rst_exit_q, rst_exit_d;
    logic           tick;
    logic           timer_load;

    assign tx   = tx_q;
    assign inc  = inc_q;
    assign busy = busy_q;
    assign ovr  = ovr_q;

    // Timer sits at zero outside a frame so START always gets a full bit.
    assign timer_load = !(state_q inside {ST_START, ST_DATA, ST_STOP});

    uart_bit_timer #(
        .DIV (DIV)
    ) u_bit_timer (
        .clk  (clk48),
        .rst  (rst),
        .load (timer_load),
        .tick (tick)
    );

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk48) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            tx_q       <= 1'b1;
            inc_q      <= 1'b0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
            rst_exit_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            tx_q       <= tx_d;
            inc_q      <= inc_d;
            busy_q     <= busy_d;
            ovr_q      <= ovr_d;
            rst_exit_q <= rst_exit_d;
        end
    end

    // Next-state logic; din_v beats a WAIT timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (en) state_d = ST_REQ;
            ST_REQ:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (din_v) begin
                    state_d = ST_START;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_REQ;
                end
            end
            ST_START: if (tick) state_d = ST_DATA;
            ST_DATA:  if (tick && (bit_cnt_q == 3'd7)) state_d = ST_STOP;
            ST_STOP: begin
                if (tick && (bit_cnt_q == STOP_LAST)) begin
                    state_d = en ? ST_REQ : ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath: byte capture, shifting, bit/stop counting and WAIT timeout.
    always_comb begin
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        wait_cnt_d = '0;
        case (state_q)
            ST_WAIT: begin
                if (din_v) begin
                    shreg_d = din;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shreg_d   = shreg_q >> 1;
                    end
                end
            end
            ST_STOP: begin
                // The bit counter is reused to count stop bits.
                if (tick) begin
                    bit_cnt_d = (bit_cnt_q == STOP_LAST) ? 3'd0 : bit_cnt_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    // Outputs are decoded from the next state so they come straight off flops.
    always_comb begin
        unique case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shreg_d[0];
            default:  tx_d = 1'b1;
        endcase
        inc_d      = (state_d == ST_REQ);
        busy_d     = state_d inside {ST_START, ST_DATA, ST_STOP};
        // A strobe held through reset is forgiven on the first cycle out of it.
        ovr_d      = ovr_q | (din_v && (state_q != ST_WAIT) && !rst_exit_q);
        rst_exit_d = 1'b0;
    end

endmodule

// File: tb/tb_usb_status_uart_tx.sv
// Directed bench for usb_status_uart_tx at DIV=16. Two instances share the
// stimulus: one with one stop bit, one with two; sel picks the one checked.
module tb_usb_status_uart_tx;

    localparam int unsigned DIVB = 16;

    logic       clk48;
    logic       rst;
    logic       en;
    logic [7:0] din;
    logic       din_v;
    logic       tx1, inc1, busy1, ovr1;
    logic       tx2, inc2, busy2, ovr2;
    logic       sel;
    logic       tx_o, inc_o, busy_o, ovr_o;

    int unsigned n_vec;
    int unsigned n_err;

    usb_status_uart_tx #(
        .BAUD      (3_000_000),
        .STOP_BITS (1),
        .WAIT_MAX  (4)
    ) dut1 (
        .clk48 (clk48), .rst (rst), .en (en), .inc (inc1), .din (din),
        .din_v (din_v), .tx (tx1), .busy (busy1), .ovr (ovr1)
    );

    usb_status_uart_tx #(
        .BAUD      (3_000_000),
        .STOP_BITS (2),
        .WAIT_MAX  (4)
    ) dut2 (
        .clk48 (clk48), .rst (rst), .en (en), .inc (inc2), .din (din),
        .din_v (din_v), .tx (tx2), .busy (busy2), .ovr (ovr2)
    );

    assign tx_o   = sel ? tx2   : tx1;
    assign inc_o  = sel ? inc2  : inc1;
    assign busy_o = sel ? busy2 : busy1;
    assign ovr_o  = sel ? ovr2  : ovr1;

    initial clk48 = 1'b0;
    always #5 clk48 = ~clk48;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk48);
        #1;
    endtask

    function automatic logic exp_tx(input logic [7:0] b, input int unsigned i);
        int unsigned k;
        k = i / DIVB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    // Called while inc is observed high: data strobe arrives in the WAIT cycle.
    task automatic handshake(input logic [7:0] b);
        chk("inc_pulse", {31'd0, inc_o}, 32'd1);
        step();
        chk("inc_low", {31'd0, inc_o}, 32'd0);
        din   = b;
        din_v = 1'b1;
        step();
        din_v = 1'b0;
    endtask

    // Cycle-by-cycle check of tx/busy from the start bit onward.
    task automatic check_frame(input logic [7:0] b, input int ncyc,
                               input int drop_at, input int pulse_at);
        for (int i = 0; i < ncyc; i++) begin
            if (i > 0) step();
            chk($sformatf("tx_%02h_c%0d", b, i), {31'd0, tx_o},
                {31'd0, exp_tx(b, i)});
            chk($sformatf("busy_%02h_c%0d", b, i), {31'd0, busy_o}, 32'd1);
            din_v = (i == pulse_at);
            if (i == pulse_at) din = 8'h00;
            if (i == drop_at) en = 1'b0;
        end
        din_v = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        sel   = 1'b0;
        rst   = 1'b1;
        en    = 1'b0;
        din   = 8'h00;
        din_v = 1'b0;

        // Reset values
        step();
        step();
        chk("rst_tx",   {31'd0, tx_o},   32'd1);
        chk("rst_inc",  {31'd0, inc_o},  32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_ovr",  {31'd0, ovr_o},  32'd0);

        // Byte 0x41, then the next request one cycle after the stop bit
        rst = 1'b0;
        en  = 1'b1;
        step();
        handshake(8'h41);
        check_frame(8'h41, 10 * DIVB, -1, -1);
        step();
        chk("post41_inc",  {31'd0, inc_o},  32'd1);
        chk("post41_busy", {31'd0, busy_o}, 32'd0);
        chk("post41_tx",   {31'd0, tx_o},   32'd1);

        // No strobe: WAIT times out and re-requests
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("to_inc_%0d", k),  {31'd0, inc_o},  32'd0);
            chk($sformatf("to_busy_%0d", k), {31'd0, busy_o}, 32'd0);
            chk($sformatf("to_tx_%0d", k),   {31'd0, tx_o},   32'd1);
        end
        step();
        chk("to_reinc", {31'd0, inc_o}, 32'd1);

        // Stale strobe held across reset release
        rst   = 1'b1;
        din   = 8'hEE;
        din_v = 1'b1;
        step();
        step();
        rst = 1'b0;
        en  = 1'b1;
        step();
        din_v = 1'b0;
        chk("stale_tx",   {31'd0, tx_o},   32'd1);
        chk("stale_busy", {31'd0, busy_o}, 32'd0);
        handshake(8'h5A);
        check_frame(8'h5A, 10 * DIVB, -1, -1);
        chk("stale_ovr", {31'd0, ovr_o}, 32'd0);

        // en dropped mid-DATA of 0xFF
        step();
        handshake(8'hFF);
        check_frame(8'hFF, 10 * DIVB, 40, -1);
        step();
        chk("drop_inc",  {31'd0, inc_o},  32'd0);
        chk("drop_busy", {31'd0, busy_o}, 32'd0);
        chk("drop_tx",   {31'd0, tx_o},   32'd1);
        for (int k = 0; k < 20; k++) begin
            step();
            chk($sformatf("idle_inc_%0d", k), {31'd0, inc_o}, 32'd0);
        end

        // Extra strobe mid-DATA sets sticky ovr, frame unchanged
        en = 1'b1;
        step();
        handshake(8'hC3);
        check_frame(8'hC3, 10 * DIVB, -1, 50);
        step();
        chk("ovr_set", {31'd0, ovr_o}, 32'd1);
        for (int k = 0; k < 10; k++) step();
        chk("ovr_sticky", {31'd0, ovr_o}, 32'd1);
        rst = 1'b1;
        en  = 1'b0;
        step();
        chk("ovr_clr", {31'd0, ovr_o}, 32'd0);

        // Two stop bits, reset during the second one
        step();
        sel = 1'b1;
        rst = 1'b0;
        en  = 1'b1;
        step();
        handshake(8'h41);
        check_frame(8'h41, 10 * DIVB + 1, -1, -1);
        rst = 1'b1;
        step();
        chk("midstop_tx",   {31'd0, tx_o},   32'd1);
        chk("midstop_inc",  {31'd0, inc_o},  32'd0);
        chk("midstop_busy", {31'd0, busy_o}, 32'd0);
        rst = 1'b0;
        step();
        chk("restart_inc",  {31'd0, inc_o},  32'd1);
        chk("restart_busy", {31'd0, busy_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
